// File: rtl/msrv32_fetch_ctrl.sv
// In-order instruction fetch sequencer: drives the PC register, issues word fetches, buffers responses for decode.
// Optional misaligned-PC trap entry is enabled by defining MSRV32_MISALIGN_TRAP_EN.
module msrv32_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_mux_out,
  input  logic        flush_in,
  input  logic [31:0] flush_target_in,
  output logic        imem_req_valid_out,
  input  logic        imem_req_ready_in,
  output logic [31:0] imem_addr_out,
  input  logic        imem_rsp_valid_in,
  input  logic [31:0] imem_rsp_data_in,
  input  logic        imem_rsp_err_in,
  output logic        instr_valid_out,
  input  logic        instr_ready_in,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        instr_err_out,
  output logic        instr_misalign_out
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = (DEPTH > 3) ? 3 : 2;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_DRAIN} state_t;

  logic clk;
  logic rst;
  assign clk = ms_riscv32_mp_clk_in;
  assign rst = ms_riscv32_mp_rst_in;

  state_t        state_q, state_d;
  logic [CW-1:0] fifo_count_q, fifo_count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [31:0] fifo_pc_q   [DEPTH];
  logic [31:0] fifo_data_q [DEPTH];
  logic        fifo_err_q  [DEPTH];
  logic [31:0] tag_pc_q    [DEPTH];

  logic        active, is_run, flush, credit_ok, fire;
  logic        rsp_keep, push, pop, pc_misaligned, mis_push;
  logic [31:0] push_pc, push_data;
  logic        push_err;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign active    = (state_q != ST_BOOT);
  assign is_run    = (state_q == ST_RUN);
  assign flush     = flush_in && active;
  // Credits come from registered state only, so a pop never frees a slot in the same cycle.
  assign credit_ok = (fifo_count_q + outstanding_q) < DEPTH_C;

  assign imem_req_valid_out = is_run && credit_ok && !flush_in && !pc_misaligned;
  assign imem_addr_out      = {pc_in[31:2], 2'b00};
  assign fire               = imem_req_valid_out && imem_req_ready_in;

  assign rsp_keep  = imem_rsp_valid_in && (discard_q == '0) && active;
  assign push      = !flush && (rsp_keep || mis_push);
  assign pop       = instr_valid_out && instr_ready_in;
  assign push_pc   = mis_push ? pc_in : tag_pc_q[tag_rd_q];
  assign push_data = mis_push ? 32'h0000_0013 : imem_rsp_data_in;
  assign push_err  = mis_push ? 1'b0 : imem_rsp_err_in;

`ifdef MSRV32_MISALIGN_TRAP_EN
  logic mis_stall_q;
  logic fifo_mis_q [DEPTH];

  assign pc_misaligned = (pc_in[1:0] != 2'b00);
  // One trap entry per misaligned PC; fetch then waits for a redirect.
  assign mis_push = is_run && credit_ok && pc_misaligned && !flush_in && !mis_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_stall_q <= 1'b0;
    end else if (flush) begin
      mis_stall_q <= 1'b0;
    end else if (mis_push) begin
      mis_stall_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mis_q[fifo_wr_q] <= mis_push;
    end
  end

  assign instr_misalign_out = instr_valid_out && fifo_mis_q[fifo_rd_q];
`else
  assign pc_misaligned      = 1'b0;
  assign mis_push           = 1'b0;
  assign instr_misalign_out = 1'b0;
`endif

  assign instr_valid_out = (fifo_count_q != '0);
  assign instr_out       = instr_valid_out ? fifo_data_q[fifo_rd_q] : 32'h0;
  assign instr_pc_out    = instr_valid_out ? fifo_pc_q[fifo_rd_q] : 32'h0;
  assign instr_err_out   = instr_valid_out && fifo_err_q[fifo_rd_q];

  always_comb begin
    pc_mux_out = pc_in;
    if (state_q == ST_BOOT) begin
      pc_mux_out = RESET_PC;
    end else if (flush_in) begin
      pc_mux_out = flush_target_in;
    end else if (fire) begin
      pc_mux_out = pc_in + 32'd4;
    end
  end

  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    fifo_count_d  = fifo_count_q;
    fifo_rd_d     = fifo_rd_q;
    fifo_wr_d     = fifo_wr_q;
    tag_rd_d      = tag_rd_q;
    tag_wr_d      = tag_wr_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      default: begin
        if (flush) begin
          // Everything still in flight is dropped, including a response landing this cycle.
          if (imem_rsp_valid_in) begin
            outstanding_d = outstanding_q - CW'(1);
          end
          discard_d    = outstanding_d;
          state_d      = (outstanding_d != '0) ? ST_DRAIN : ST_RUN;
          fifo_count_d = '0;
          fifo_rd_d    = '0;
          fifo_wr_d    = '0;
          tag_rd_d     = '0;
          tag_wr_d     = '0;
        end else begin
          if (fire) begin
            outstanding_d = outstanding_d + CW'(1);
            tag_wr_d      = ptr_inc(tag_wr_q);
          end
          if (imem_rsp_valid_in) begin
            outstanding_d = outstanding_d - CW'(1);
            if (discard_q != '0) begin
              discard_d = discard_q - CW'(1);
            end
          end
          if (rsp_keep) begin
            tag_rd_d = ptr_inc(tag_rd_q);
          end
          if (push) begin
            fifo_wr_d    = ptr_inc(fifo_wr_q);
            fifo_count_d = fifo_count_d + CW'(1);
          end
          if (pop) begin
            fifo_rd_d    = ptr_inc(fifo_rd_q);
            fifo_count_d = fifo_count_d - CW'(1);
          end
          if (state_q == ST_DRAIN && discard_d == '0) begin
            state_d = ST_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      outstanding_q <= '0;
      discard_q     <= '0;
      fifo_count_q  <= '0;
      fifo_rd_q     <= '0;
      fifo_wr_q     <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fifo_count_q  <= fifo_count_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_wr_q     <= fifo_wr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[fifo_wr_q]   <= push_pc;
      fifo_data_q[fifo_wr_q] <= push_data;
      fifo_err_q[fifo_wr_q]  <= push_err;
    end
    if (fire) begin
      tag_pc_q[tag_wr_q] <= pc_in;
    end
  end

endmodule
